// File: rtl/auto_daq_pkg.sv
// rtl/auto_daq_pkg.sv - shared types, timing defaults and helpers for auto_daq_multi
// Purpose: state encoding, default timing constants, and a lowest-set-bit search
//          used to walk the enabled chains in ascending order.
// Ports:   none (package).
package auto_daq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHIPRESET,
    S_POWOND,
    S_RELEASE,
    S_ACQ,
    S_WAIT,
    S_SRO,
    S_WAIT_READ,
    S_END
  } daq_state_t;

  localparam int DEF_N_CHAIN     = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_T_PWR_RST   = 8;
  localparam int DEF_T_RST_START = 40;
  localparam int DEF_T_SRO       = 16;
  localparam int DEF_T_RO_MAX    = 65535;

  // Index of the lowest set bit of vec at or above 'from'; 8 means none found.
  function automatic logic [3:0] lowest_set_from(input logic [7:0] vec, input logic [3:0] from);
    lowest_set_from = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i] && (4'(i) >= from)) lowest_set_from = 4'(i);
    end
  endfunction

endpackage

// File: rtl/auto_daq_multi_edge_sync.sv
// rtl/auto_daq_multi_edge_sync.sv - vector 2-FF synchroniser with edge detect
// Purpose: brings W asynchronous lines into the Clk domain and flags edges on
//          the synchronised value.
// Ports:   Clk, reset (sync, active high), din[W] async in,
//          sync[W] synchronised level, rise[W]/fall[W] one-cycle edge flags.
module daq_edge_sync #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] meta;
  logic [W-1:0] prev;

  always_ff @(posedge Clk) begin
    if (reset) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = prev & ~sync;

endmodule

// File: rtl/auto_daq_multi.sv
// rtl/auto_daq_multi.sv - power-pulsed DAQ sequencer for N_CHAIN ASIC chains
// Purpose: runs reset -> acquire -> readout cycles, single shot or looped,
//          reading enabled chains one after another in ascending order.
// Ports:   Clk, reset (sync, active high); start, stop, loop_mode, run_count,
//          T_acquisition, chain_en: run control (latched on leaving IDLE);
//          Chipsatb, End_Readout: async per-chain status from the ASICs;
//          Reset_b, Start_Acq, Start_Readout, Pwr_on_*: ASIC pad controls;
//          Once_end, busy, cycle_done, timeout_err: status.
// Option:  AUTO_DAQ_TIMEOUT_EN enables the WAIT_READ watchdog (T_RO_MAX cycles).
module auto_daq_multi
  import auto_daq_pkg::*;
#(
  parameter int N_CHAIN     = DEF_N_CHAIN,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int T_PWR_RST   = DEF_T_PWR_RST,
  parameter int T_RST_START = DEF_T_RST_START,
  parameter int T_SRO       = DEF_T_SRO,
  parameter int T_RO_MAX    = DEF_T_RO_MAX
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_mode,
  input  logic [CNT_W-1:0]   run_count,
  input  logic [CNT_W-1:0]   T_acquisition,
  input  logic [N_CHAIN-1:0] chain_en,
  input  logic [N_CHAIN-1:0] Chipsatb,
  input  logic [N_CHAIN-1:0] End_Readout,
  output logic               Reset_b,
  output logic               Start_Acq,
  output logic [N_CHAIN-1:0] Start_Readout,
  output logic               Pwr_on_a,
  output logic               Pwr_on_d,
  output logic               Pwr_on_dac,
  output logic               Pwr_on_adc,
  output logic               Once_end,
  output logic               busy,
  output logic [CNT_W-1:0]   cycle_done,
  output logic               timeout_err
);

`ifdef AUTO_DAQ_TIMEOUT_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_X     = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(T_PWR_RST - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(T_RST_START - 1);
  localparam logic [CNT_W-1:0] SRO_LAST  = CNT_W'(T_SRO - 1);
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(T_RO_MAX - 1);

  daq_state_t         state;
  logic [N_CHAIN-1:0] en_q;
  logic               loop_q;
  logic [CNT_W-1:0]   run_q;
  logic [CNT_W-1:0]   t_acq_q;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         sel;
  logic               stop_pend;
  logic               timeout_q;

  logic [N_CHAIN-1:0] csb_sync, csb_rise, csb_fall;
  logic [N_CHAIN-1:0] er_sync, er_rise, er_fall;

  daq_edge_sync #(.W(N_CHAIN), .RST_VAL({N_CHAIN{1'b1}})) u_csb_sync (
    .Clk   (Clk),
    .reset (reset),
    .din   (Chipsatb),
    .sync  (csb_sync),
    .rise  (csb_rise),
    .fall  (csb_fall)
  );

  daq_edge_sync #(.W(N_CHAIN), .RST_VAL({N_CHAIN{1'b0}})) u_er_sync (
    .Clk   (Clk),
    .reset (reset),
    .din   (End_Readout),
    .sync  (er_sync),
    .rise  (er_rise),
    .fall  (er_fall)
  );

  // Edge/level flags the sequencer does not act on.
  logic unused_sync;
  assign unused_sync = ^{csb_rise, er_rise, er_sync};

  logic [7:0] en8;
  logic [7:0] er_fall8;
  logic [3:0] first_idx;
  logic [3:0] next_idx;
  logic       acq_full, acq_done, all_ready, er_done, wd_hit, rerun;

  assign en8       = 8'(en_q);
  assign er_fall8  = 8'(er_fall);
  assign first_idx = lowest_set_from(en8, 4'd0);
  assign next_idx  = lowest_set_from(en8, {1'b0, sel} + 4'd1);

  assign acq_full  = |(csb_fall & en_q);
  // T_acquisition of 0 still yields one cycle because cnt starts at 0.
  assign acq_done  = ({1'b0, cnt} + ONE_X) >= {1'b0, t_acq_q};
  // Level test: disabled chains never hold the readout back.
  assign all_ready = &(csb_sync | ~en_q);
  assign er_done   = er_fall8[sel];
  assign wd_hit    = WD_EN && (cnt == WD_LAST);
  assign rerun     = loop_q && !(stop_pend || stop) &&
                     ((run_q == '0) || (({1'b0, cycle_done} + ONE_X) < {1'b0, run_q}));

  assign Pwr_on_adc  = 1'b0;
  assign timeout_err = WD_EN ? timeout_q : 1'b0;

  always_ff @(posedge Clk) begin
    if (reset) begin
      state         <= S_IDLE;
      en_q          <= '0;
      loop_q        <= 1'b0;
      run_q         <= '0;
      t_acq_q       <= '0;
      cnt           <= '0;
      sel           <= '0;
      stop_pend     <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_done    <= '0;
      Reset_b       <= 1'b1;
      Start_Acq     <= 1'b0;
      Start_Readout <= '0;
      Pwr_on_a      <= 1'b0;
      Pwr_on_d      <= 1'b0;
      Pwr_on_dac    <= 1'b0;
      Once_end      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      Once_end <= 1'b0;
      if (state != S_IDLE && stop) stop_pend <= 1'b1;

      // Outputs are assigned on the transition so they line up with the new state.
      case (state)
        S_IDLE: begin
          if (start && chain_en != '0) begin
            en_q       <= chain_en;
            loop_q     <= loop_mode;
            run_q      <= run_count;
            t_acq_q    <= T_acquisition;
            cycle_done <= '0;
            stop_pend  <= 1'b0;
            timeout_q  <= 1'b0;
            busy       <= 1'b1;
            Reset_b    <= 1'b0;
            Pwr_on_a   <= 1'b1;
            Pwr_on_dac <= 1'b1;
            state      <= S_CHIPRESET;
          end
        end
        S_CHIPRESET: begin
          cnt      <= '0;
          Pwr_on_d <= 1'b1;
          state    <= S_POWOND;
        end
        S_POWOND: begin
          if (cnt == PWR_LAST) begin
            cnt     <= '0;
            Reset_b <= 1'b1;
            state   <= S_RELEASE;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        S_RELEASE: begin
          if (cnt == RST_LAST) begin
            cnt       <= '0;
            Start_Acq <= 1'b1;
            state     <= S_ACQ;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        S_ACQ: begin
          if (acq_full || acq_done) begin
            Start_Acq <= 1'b0;
            state     <= S_WAIT;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        S_WAIT: begin
          if (all_ready) begin
            cnt           <= '0;
            sel           <= first_idx[2:0];
            Start_Readout <= N_CHAIN'(8'd1 << first_idx[2:0]);
            Pwr_on_d      <= 1'b0;
            state         <= S_SRO;
          end
        end
        S_SRO: begin
          if (cnt == SRO_LAST) begin
            cnt           <= '0;
            Start_Readout <= '0;
            Pwr_on_a      <= 1'b0;
            Pwr_on_dac    <= 1'b0;
            state         <= S_WAIT_READ;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        S_WAIT_READ: begin
          if (er_done && !next_idx[3]) begin
            cnt           <= '0;
            sel           <= next_idx[2:0];
            Start_Readout <= N_CHAIN'(8'd1 << next_idx[2:0]);
            Pwr_on_a      <= 1'b1;
            Pwr_on_dac    <= 1'b1;
            state         <= S_SRO;
          end else if (er_done || wd_hit) begin
            // A watchdog expiry abandons the remaining chains.
            if (!er_done) timeout_q <= 1'b1;
            Once_end <= 1'b1;
            state    <= S_END;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        S_END: begin
          cycle_done <= cycle_done + ONE_C;
          if (rerun) begin
            Reset_b    <= 1'b0;
            Pwr_on_a   <= 1'b1;
            Pwr_on_dac <= 1'b1;
            state      <= S_CHIPRESET;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
